// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle execute stage with shift-add multiplier and zero/carry flags
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 1,
    parameter int SHAMT_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    output logic [ADDR_WIDTH-1:0] read_register1,
    output logic [ADDR_WIDTH-1:0] read_register2,
    input  logic [DATA_WIDTH-1:0] read_data1,
    input  logic [DATA_WIDTH-1:0] read_data2,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_register,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              opcode_q, opcode_d;
    logic [ADDR_WIDTH-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [2*DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    zero_q, zero_d, carry_q, carry_d;

    logic [DATA_WIDTH:0]     alu_wide;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_carry;
    logic [2*DATA_WIDTH-1:0] acc_next;

    // Single-cycle ops read the register file directly during EXEC
    always_comb begin
        alu_wide  = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (opcode_q)
            OP_ADD: begin
                alu_wide  = {1'b0, read_data1} + {1'b0, read_data2};
                alu_res   = alu_wide[DATA_WIDTH-1:0];
                alu_carry = alu_wide[DATA_WIDTH];
            end
            OP_SUB: begin
                alu_res   = read_data1 - read_data2;
                alu_carry = (read_data1 < read_data2);
            end
            OP_AND:  alu_res = read_data1 & read_data2;
            OP_OR:   alu_res = read_data1 | read_data2;
            OP_XOR:  alu_res = read_data1 ^ read_data2;
            OP_SHL:  alu_res = read_data1 << read_data2[SHAMT_WIDTH-1:0];
            OP_SHR:  alu_res = read_data1 >> read_data2[SHAMT_WIDTH-1:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        acc_next = op_b_q[0] ? (acc_q + op_a_q) : acc_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    opcode_d = opcode;
                    rs1_d    = rs1;
                    rs2_d    = rs2;
                    rd_d     = rd;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                op_a_d = {{DATA_WIDTH{1'b0}}, read_data1};
                op_b_d = read_data2;
                if (opcode_q == OP_MUL) begin
                    acc_d   = '0;
                    cnt_d   = CW'(DATA_WIDTH);
                    state_d = S_MUL;
                end else begin
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    carry_d  = alu_carry;
                    state_d  = S_WB;
                end
            end
            S_MUL: begin
                acc_d  = acc_next;
                op_a_d = op_a_q << 1;
                op_b_d = op_b_q >> 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = acc_next[DATA_WIDTH-1:0];
                    zero_d   = (acc_next[DATA_WIDTH-1:0] == '0);
                    carry_d  = |acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_d  = S_WB;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    // Strobes decode straight from state so a reset in WB kills the write at once
    assign instr_ready    = (state_q == S_IDLE);
    assign write_enable   = (state_q == S_WB);
    assign done           = (state_q == S_WB);
    assign read_register1 = rs1_q;
    assign read_register2 = rs2_q;
    assign write_register = rd_q;
    assign write_data     = result_q;
    assign zero_flag      = zero_q;
    assign carry_flag     = carry_q;

endmodule
